// File: rtl/cplx_result_requant.sv
//-----------------------------------------------------------------------------
// cplx_result_requant
//
// Requantizes a complex product pair (cr, ci) from Q2.(2*WL-2) to Q1.(WL-1)
// with saturation, then buffers the {yr, yi} result in a small FIFO with a
// valid/ready handshake on both sides.
//
// Build option:
//   CPLX_REQUANT_ROUND_EN  defined   -> round-half-up (add 2^(WL-2), then shift)
//                          undefined -> truncate (floor)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   cr/ci valid this cycle
//   in_ready   out  block accepts a sample this cycle (count < DEPTH)
//   cr, ci     in   WL_out-bit signed real/imaginary products
//   out_valid  out  yr/yi hold a valid sample (count != 0)
//   out_ready  in   downstream consumes the head sample
//   yr, yi     out  WL-bit signed requantized head sample
//   count      out  FIFO occupancy, 0..DEPTH
//   sat_flag   out  sticky saturation indicator, cleared only by reset
//   sat_cnt    out  saturating count of samples that saturated
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module cplx_result_requant #(
  parameter int WL     = 14,
  parameter int WL_out = 28,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WL_out-1:0]   cr,
  input  logic signed [WL_out-1:0]   ci,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WL-1:0]       yr,
  output logic signed [WL-1:0]       yi,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       sat_flag,
  output logic [7:0]                 sat_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WL_out + 1;        // one guard bit so the rounding add cannot wrap
  localparam int SW = WL_out - WL + 2;   // width of the shifted value before saturation

  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (WL-1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 << (WL-1)));
  localparam logic signed [WL-1:0] OUT_MAX = {1'b0, {(WL-1){1'b1}}};
  localparam logic signed [WL-1:0] OUT_MIN = {1'b1, {(WL-1){1'b0}}};

  // Arithmetic shift right by WL-1 (optionally after the half-LSB add),
  // clamped to the WL-bit signed range.
  function automatic logic signed [WL-1:0] requant(
    input  logic signed [WL_out-1:0] x,
    output logic                     sat
  );
    logic signed [EW-1:0] ext;
    logic signed [SW-1:0] sh;
    ext = {x[WL_out-1], x};
`ifdef CPLX_REQUANT_ROUND_EN
    ext = ext + EW'(1 << (WL-2));
`else
    ext = ext;
`endif
    sh  = ext[EW-1:WL-1];
    sat = 1'b0;
    if (sh > SAT_MAX) begin
      sat     = 1'b1;
      requant = OUT_MAX;
    end else if (sh < SAT_MIN) begin
      sat     = 1'b1;
      requant = OUT_MIN;
    end else begin
      requant = sh[WL-1:0];
    end
  endfunction

  logic [2*WL-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            sat_flag_q, sat_flag_d;
  logic [7:0]      sat_cnt_q,  sat_cnt_d;

  logic signed [WL-1:0] yr_new, yi_new;
  logic                 sat_r, sat_i;
  logic                 push, pop;

  always_comb begin
    // in_ready is gated by reset so it is low asynchronously while reset is held.
    in_ready  = !reset && (count_q < CW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;

    yr_new = requant(cr, sat_r);
    yi_new = requant(ci, sat_i);

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    sat_flag_d = sat_flag_q;
    sat_cnt_d  = sat_cnt_q;
    if (push && (sat_r || sat_i)) begin
      sat_flag_d = 1'b1;
      if (sat_cnt_q != 8'hFF) sat_cnt_d = sat_cnt_q + 8'd1;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sat_flag_q <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sat_flag_q <= sat_flag_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; its contents are only
  // visible through the head pointer when count is non-zero, and a reset
  // clears count, so stale entries can never reach the outputs.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {yr_new, yi_new};
  end

  // Outputs are forced to zero when empty, which also covers the reset case.
  assign yr       = out_valid ? mem_q[rd_ptr_q][2*WL-1:WL] : '0;
  assign yi       = out_valid ? mem_q[rd_ptr_q][WL-1:0]    : '0;
  assign count    = count_q;
  assign sat_flag = sat_flag_q;
  assign sat_cnt  = sat_cnt_q;

endmodule

// File: tb/tb_cplx_result_requant.sv
//-----------------------------------------------------------------------------
// tb_cplx_result_requant
//
// Directed bench for cplx_result_requant with hand-computed expectations.
// Inputs change 1 ns after each rising edge; outputs are sampled at that
// same point, well clear of the active edge.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cplx_result_requant;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [27:0] cr;
  logic signed [27:0] ci;
  logic               out_valid;
  logic               out_ready;
  logic signed [13:0] yr;
  logic signed [13:0] yi;
  logic [2:0]         count;
  logic               sat_flag;
  logic [7:0]         sat_cnt;

  int checks = 0;
  int errors = 0;

  cplx_result_requant #(.WL(14), .WL_out(28), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cr        (cr),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .yr        (yr),
    .yi        (yi),
    .count     (count),
    .sat_flag  (sat_flag),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int r, input int i);
    cr = 28'(r);
    ci = 28'(i);
  endtask

  // One accepted sample; returns 1 ns after the accepting edge.
  task automatic send(input int r, input int i);
    drive(r, i);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int vr, vi;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cr        = '0;
    ci        = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",     count,     0);
    check("rst_out_valid", out_valid, 0);
    check("rst_yr",        yr,        0);
    check("rst_yi",        yi,        0);
    check("rst_sat_flag",  sat_flag,  0);
    check("rst_sat_cnt",   sat_cnt,   0);
    check("rst_in_ready",  in_ready,  0);
    reset = 1'b0;
    #1;
    check("rel_in_ready",  in_ready,  1);

    // Basic value: 8192 -> 1, -8192 -> -1, latency 1
    out_ready = 1'b1;
    send(8192, -8192);
    check("basic_valid", out_valid, 1);
    check("basic_yr",    yr,        1);
    check("basic_yi",    yi,        -1);
    check("basic_sat",   sat_flag,  0);
    tick();
    check("basic_drain", count,     0);

    // Half-LSB: rounding vs truncation
    send(4096, -4096);
`ifdef CPLX_REQUANT_ROUND_EN
    check("half_yr", yr, 1);
    check("half_yi", yi, 0);
`else
    check("half_yr", yr, 0);
    check("half_yi", yi, -1);
`endif
    tick();

    // Largest in-range values in both directions: no saturation
    send(8191 * 8192, -8192 * 8192);
    check("edge_yr",      yr,       8191);
    check("edge_yi",      yi,       -8192);
    check("edge_sat",     sat_flag, 0);
    check("edge_sat_cnt", sat_cnt,  0);
    tick();

    // Saturation: +2^26 -> 8191, -2^27 -> -8192
    drive(1 << 26, -(1 << 27));
    in_valid = 1'b1;
    tick();
    check("sat_yr",   yr,       8191);
    check("sat_yi",   yi,       -8192);
    check("sat_flag", sat_flag, 1);
    check("sat_cnt1", sat_cnt,  1);
    repeat (299) tick();
    check("sat_cnt255", sat_cnt, 255);
    drive(8192, 8192);
    tick();
    in_valid = 1'b0;
    check("sat_sticky",   sat_flag, 1);
    check("sat_cnt_hold", sat_cnt,  255);
    check("post_sat_yr",  yr,       1);
    tick();

    // Backpressure: fill to DEPTH, fifth push refused, head held stable
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(k * 8192, -k * 8192);
      in_valid = 1'b1;
      tick();
      if (k == 4) begin
        check("bp_full_ready", in_ready, 0);
        check("bp_full_count", count,    4);
      end
    end
    in_valid = 1'b0;
    check("bp_fifth_count", count, 4);
    check("bp_hold_yr",     yr,    1);
    check("bp_hold_yi",     yi,    -1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("bp_order_yr", yr, k);
      check("bp_order_yi", yi, -k);
      tick();
    end
    check("bp_empty_valid", out_valid, 0);
    check("bp_empty_count", count,     0);
    tick();
    check("pop_empty_count", count, 0);

    // Streaming: push and pop every cycle, count stays 1, order preserved
    for (int i = 0; i < 1000; i++) begin
      vr = (i % 8000) - 4000;
      vi = 3999 - ((i * 7) % 8000);
      drive(vr * 8192, vi * 8192);
      in_valid = 1'b1;
      tick();
      check("stream_count", count, 1);
      check("stream_yr",    yr,    vr);
      check("stream_yi",    yi,    vi);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", count, 0);

    // Reset mid-operation with three samples queued
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) send(k * 8192, k * 8192);
    check("mid_count_pre", count, 3);
    reset = 1'b1;
    #1;
    check("mid_count",     count,     0);
    check("mid_out_valid", out_valid, 0);
    check("mid_yr",        yr,        0);
    check("mid_in_ready",  in_ready,  0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rel_ready", in_ready, 1);
    @(posedge clk); #1;
    check("mid_no_stale", out_valid, 0);
    send(7 * 8192, -3 * 8192);
    check("mid_new_yr",    yr,    7);
    check("mid_new_yi",    yi,    -3);
    check("mid_new_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
